// File: rtl/seq_det_sched_pkg.sv
// Shared types and defaults for the two-channel 101100 detector scheduler.
// Holds the scheduler and detector-core state encodings.
package seq_det_sched_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_CNT_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DRAIN,
    REPORT
  } sched_st_t;

  typedef enum logic [2:0] {
    C_IDLE,
    C_S1,
    C_S10,
    C_S101,
    C_S1011,
    C_S10110
  } core_st_t;

endpackage

// File: rtl/seq_det_sched_if.sv
// Request/result handshake bundle between word sources, scheduler
// and result collector.
interface seq_det_sched_if
  import seq_det_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
);

  logic [1:0]       req_valid;
  logic [WIDTH-1:0] req_data0;
  logic [WIDTH-1:0] req_data1;
  logic [1:0]       req_ready;
  logic             res_valid;
  logic             res_id;
  logic [CNT_W-1:0] res_hits;
  logic             res_ready;
  logic             busy;

  modport master (
    output req_valid, req_data0, req_data1, res_ready,
    input  req_ready, res_valid, res_id, res_hits, busy
  );

  modport slave (
    input  req_valid, req_data0, req_data1, res_ready,
    output req_ready, res_valid, res_id, res_hits, busy
  );

endinterface

// File: rtl/seq_det_core.sv
// Serial 101100 detector; restarts from idle after each hit.
// b is registered and reports the bit seen on the previous cycle.
module seq_det_core
  import seq_det_sched_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic seq,
  output logic b
);

  core_st_t st_q;
  core_st_t st_d;
  logic     hit;

  always_comb begin
    st_d = C_IDLE;
    hit  = 1'b0;
    unique case (st_q)
      C_IDLE:   st_d = seq ? C_S1    : C_IDLE;
      C_S1:     st_d = seq ? C_S1    : C_S10;
      C_S10:    st_d = seq ? C_S101  : C_IDLE;
      C_S101:   st_d = seq ? C_S1011 : C_IDLE;
      C_S1011:  st_d = seq ? C_S1    : C_S10110;
      C_S10110: begin
        st_d = seq ? C_S1 : C_IDLE;
        hit  = ~seq;
      end
      default:  st_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= C_IDLE;
      b    <= 1'b0;
    end else if (clr) begin
      st_q <= C_IDLE;
      b    <= 1'b0;
    end else begin
      st_q <= st_d;
      b    <= hit;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Round-robin scheduler feeding two channels' words serially into
// one shared detector core and returning tagged hit counts.
module seq_det_sched
  import seq_det_sched_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
)
(
  input  logic           clk,
  input  logic           rst,
  seq_det_sched_if.slave bus
);

  localparam int BW = $clog2(WIDTH) + 1;

  sched_st_t        state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [CNT_W-1:0] hits_q, hits_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic [1:0]       grant;
  logic             g;
  logic             clr;
  logic             seq;
  logic             b;

  seq_det_core u_core (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .seq (seq),
    .b   (b)
  );

  assign seq = (state_q == SHIFT) & shreg_q[WIDTH-1];

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    hits_d   = hits_q;
    id_d     = id_q;
    last_d   = last_q;
    grant    = 2'b00;
    clr      = 1'b0;
    g        = (&bus.req_valid) ? ~last_q
                                : bus.req_valid[1];
    unique case (state_q)
      IDLE: begin
        if (|bus.req_valid) begin
          grant[g] = 1'b1;
          shreg_d  = g ? bus.req_data1 : bus.req_data0;
          id_d     = g;
          last_d   = g;
          hits_d   = '0;
          bitcnt_d = '0;
          clr      = 1'b1;
          state_d  = SHIFT;
        end
      end
      SHIFT: begin
        shreg_d  = shreg_q << 1;
        bitcnt_d = bitcnt_q + 1'b1;
        if (b && hits_q != '1) hits_d = hits_q + 1'b1;
        if (bitcnt_q == BW'(WIDTH - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        // last bit's hit only becomes visible here
        if (b && hits_q != '1) hits_d = hits_q + 1'b1;
        state_d = REPORT;
      end
      REPORT: begin
        if (bus.res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      bitcnt_q <= '0;
      hits_q   <= '0;
      id_q     <= 1'b0;
      last_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      bitcnt_q <= bitcnt_d;
      hits_q   <= hits_d;
      id_q     <= id_d;
      last_q   <= last_d;
    end
  end

  assign bus.req_ready = rst ? grant : 2'b00;
  assign bus.res_valid = (state_q == REPORT);
  assign bus.res_id    = id_q;
  assign bus.res_hits  = hits_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_seq_det_sched.sv
// Bench for seq_det_sched: directed and random words against a
// table-driven detector model and round-robin grant model.
module tb_seq_det_sched;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  logic last_g = 1'b1;

  seq_det_sched_if #(.WIDTH(16), .CNT_W(5)) bus ();

  seq_det_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic int model_hits(input logic [15:0] w);
    int nx [6][2] = '{'{0, 1}, '{2, 1}, '{0, 3},
                      '{0, 4}, '{5, 1}, '{0, 1}};
    int s = 0;
    int h = 0;
    for (int i = 15; i >= 0; i--) begin
      if (s == 5 && w[i] == 1'b0) h++;
      s = nx[s][w[i]];
    end
    return (h > 31) ? 31 : h;
  endfunction

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    int p;
    w = 16'($urandom);
    if ($urandom_range(0, 1) == 1) begin
      p = $urandom_range(0, 10);
      w[p +: 6] = 6'b101100;
    end
    return w;
  endfunction

  task automatic wait_accept(input int budget,
                             output int waited,
                             output logic [1:0] rr);
    waited = 0;
    #1;
    while (bus.req_ready == 2'b00 && waited < budget) begin
      @(negedge clk);
      #1;
      waited++;
    end
    rr = bus.req_ready;
  endtask

  task automatic wait_result(input int budget, input int start,
                             output int cyc);
    cyc = start;
    while (bus.res_valid !== 1'b1 && cyc < budget) begin
      @(negedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    bus.req_valid = 2'b11;
    bus.req_data0 = rand_word();
    bus.req_data1 = rand_word();
    bus.res_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL reset_req_ready got=%b exp=00", bus.req_ready);
    end
    checks++;
    if ({bus.busy, bus.res_valid, bus.res_id} !== 3'b000) begin
      failures++;
      $display("FAIL reset_flags got=%b exp=000",
               {bus.busy, bus.res_valid, bus.res_id});
    end
    checks++;
    if (bus.res_hits !== 5'd0) begin
      failures++;
      $display("FAIL reset_hits got=%0d exp=0", bus.res_hits);
    end
    @(negedge clk);
    bus.req_valid = 2'b00;
    rst = 1'b1;
    last_g = 1'b1;
  endtask

  task automatic test_two_hits();
    int wt, cyc;
    logic [1:0] rr;
    @(negedge clk);
    bus.req_data0 = 16'b1011_0010_1100_0000;
    bus.req_valid = 2'b01;
    bus.res_ready = 1'b1;
    wait_accept(5, wt, rr);
    checks++;
    if (rr !== 2'b01 || wt != 0) begin
      failures++;
      $display("FAIL two_hits_grant got=%b/%0d exp=01/0", rr, wt);
    end
    last_g = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL busy_no_ready got=%b/%b exp=1/00",
               bus.busy, bus.req_ready);
    end
    bus.req_valid = 2'b00;
    wait_result(40, 1, cyc);
    checks++;
    if (bus.res_valid !== 1'b1 || cyc != 18) begin
      failures++;
      $display("FAIL two_hits_latency got=%0d exp=18", cyc);
    end
    checks++;
    if (bus.res_id !== 1'b0 || bus.res_hits !== 5'd2) begin
      failures++;
      $display("FAIL two_hits_result got=%b/%0d exp=0/2",
               bus.res_id, bus.res_hits);
    end
  endtask

  task automatic test_words(input logic ch, input logic [15:0] w,
                            input string nm);
    int wt, cyc;
    logic [1:0] rr, er;
    @(negedge clk);
    if (ch) bus.req_data1 = w;
    else    bus.req_data0 = w;
    bus.req_valid = ch ? 2'b10 : 2'b01;
    er = ch ? 2'b10 : 2'b01;
    wait_accept(5, wt, rr);
    checks++;
    if (rr !== er) begin
      failures++;
      $display("FAIL %s_grant got=%b exp=%b", nm, rr, er);
    end
    last_g = ch;
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_result(40, 1, cyc);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== ch ||
        bus.res_hits !== 5'(model_hits(w))) begin
      failures++;
      $display("FAIL %s_result w=%h got=%b/%b/%0d exp=1/%b/%0d",
               nm, w, bus.res_valid, bus.res_id, bus.res_hits,
               ch, model_hits(w));
    end
  endtask

  task automatic test_no_hits();
    test_words(1'b1, 16'hFFFF, "ones");
    test_words(1'b1, 16'h0000, "zeros");
  endtask

  task automatic test_cross_word();
    test_words(1'b0, 16'h000B, "xword_a");
    test_words(1'b0, 16'h0000, "xword_b");
  endtask

  task automatic test_arbitration();
    int wt, cyc;
    logic [1:0] rr, er;
    logic g;
    logic [15:0] w;
    @(negedge clk);
    bus.req_data0 = rand_word();
    bus.req_data1 = rand_word();
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_accept(40, wt, rr);
      g = ~last_g;
      er = g ? 2'b10 : 2'b01;
      w = g ? bus.req_data1 : bus.req_data0;
      checks++;
      if (rr !== er || (i > 0 && wt != 0)) begin
        failures++;
        $display("FAIL arb_grant%0d got=%b/%0d exp=%b/0",
                 i, rr, wt, er);
      end
      last_g = g;
      @(negedge clk);
      if (g) bus.req_data1 = rand_word();
      else   bus.req_data0 = rand_word();
      wait_result(40, 1, cyc);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== g ||
          bus.res_hits !== 5'(model_hits(w))) begin
        failures++;
        $display("FAIL arb_result%0d got=%b/%b/%0d exp=1/%b/%0d",
                 i, bus.res_valid, bus.res_id, bus.res_hits,
                 g, model_hits(w));
      end
      @(negedge clk);
    end
    bus.req_valid = 2'b00;
  endtask

  task automatic test_random();
    int wt, cyc;
    logic [1:0] rr, er, vr;
    logic g;
    logic [15:0] w;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      vr = 2'($urandom_range(1, 3));
      bus.req_data0 = rand_word();
      bus.req_data1 = rand_word();
      bus.req_valid = vr;
      g = (vr == 2'b11) ? ~last_g : vr[1];
      er = g ? 2'b10 : 2'b01;
      w = g ? bus.req_data1 : bus.req_data0;
      wait_accept(5, wt, rr);
      checks++;
      if (rr !== er) begin
        failures++;
        $display("FAIL rand_grant%0d got=%b exp=%b", i, rr, er);
      end
      last_g = g;
      @(negedge clk);
      bus.req_valid = 2'b00;
      wait_result(40, 1, cyc);
      checks++;
      if (bus.res_valid !== 1'b1 || bus.res_id !== g ||
          bus.res_hits !== 5'(model_hits(w))) begin
        failures++;
        $display("FAIL rand_result%0d w=%h got=%b/%0d exp=%b/%0d",
                 i, w, bus.res_id, bus.res_hits, g, model_hits(w));
      end
    end
  endtask

  task automatic test_back_pressure();
    int wt, cyc, bad;
    logic [1:0] rr;
    logic [15:0] w1, w0;
    @(negedge clk);
    w1 = 16'b0010_1100_1011_0010;
    bus.req_data1 = w1;
    bus.req_valid = 2'b10;
    wait_accept(5, wt, rr);
    last_g = 1'b1;
    @(negedge clk);
    w0 = rand_word();
    bus.req_data0 = w0;
    bus.req_valid = 2'b11;
    bus.res_ready = 1'b0;
    wait_result(40, 1, cyc);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b1 ||
          bus.res_hits !== 5'(model_hits(w1)) ||
          bus.req_ready !== 2'b00) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_hold bad_cycles=%0d exp=0 hits=%0d exp=%0d",
               bad, bus.res_hits, model_hits(w1));
    end
    bus.res_ready = 1'b1;
    @(negedge clk);
    wait_accept(5, wt, rr);
    checks++;
    if (rr !== 2'b01 || wt != 0) begin
      failures++;
      $display("FAIL bp_next_accept got=%b/%0d exp=01/0", rr, wt);
    end
    last_g = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_result(40, 1, cyc);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b0 ||
        bus.res_hits !== 5'(model_hits(w0))) begin
      failures++;
      $display("FAIL bp_second got=%b/%0d exp=0/%0d",
               bus.res_id, bus.res_hits, model_hits(w0));
    end
  endtask

  task automatic test_reset_mid();
    int wt, cyc, seen;
    logic [1:0] rr;
    logic [15:0] w;
    @(negedge clk);
    bus.req_data1 = 16'b1011_0010_1100_0000;
    bus.req_valid = 2'b10;
    wait_accept(5, wt, rr);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({bus.busy, bus.res_valid, bus.res_id} !== 3'b000 ||
        bus.res_hits !== 5'd0 || bus.req_ready !== 2'b00) begin
      failures++;
      $display("FAIL mid_reset got=%b/%0d/%b exp=000/0/00",
               {bus.busy, bus.res_valid, bus.res_id},
               bus.res_hits, bus.req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    bus.req_valid = 2'b00;
    last_g = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.res_valid !== 1'b0) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL mid_no_result got=%0d exp=0", seen);
    end
    w = rand_word();
    bus.req_data0 = w;
    bus.req_data1 = rand_word();
    bus.req_valid = 2'b11;
    wait_accept(5, wt, rr);
    checks++;
    if (rr !== 2'b01) begin
      failures++;
      $display("FAIL mid_first_grant got=%b exp=01", rr);
    end
    last_g = 1'b0;
    @(negedge clk);
    bus.req_valid = 2'b00;
    wait_result(40, 1, cyc);
    checks++;
    if (bus.res_valid !== 1'b1 || bus.res_id !== 1'b0 ||
        bus.res_hits !== 5'(model_hits(w))) begin
      failures++;
      $display("FAIL mid_after got=%b/%0d exp=0/%0d",
               bus.res_id, bus.res_hits, model_hits(w));
    end
  endtask

  initial begin
    bus.req_valid = 2'b00;
    bus.req_data0 = '0;
    bus.req_data1 = '0;
    bus.res_ready = 1'b1;
    test_reset();
    test_two_hits();
    test_no_hits();
    test_arbitration();
    test_cross_word();
    test_random();
    test_back_pressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_det_sched.md
# seq_det_sched

Two-channel scheduler that shares one "101100" pattern-detector core between two requesters. Each requester hands over a WIDTH-bit word with a valid/ready handshake. The block round-robin arbitrates between the two, clears the core, and shifts the granted word into it serially, MSB first. It then returns the match count, tagged with the channel id, on a result handshake. It sits between the per-channel word sources and the result collector, and is the only driver of the detector core.

## Interface
- WIDTH, 16: bits per request word.
- CNT_W, 5: width of the hit counter.
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_valid  in  2  bit i: channel i has a word pending.
- req_data0  in  WIDTH  channel 0 word; sampled on accept.
- req_data1  in  WIDTH  channel 1 word; sampled on accept.
- req_ready  out  2  one-hot one-cycle accept pulse; reset 2'b00.
- res_valid  out  1  result available; reset 0.
- res_id  out  1  channel of the result; reset 0.
- res_hits  out  CNT_W  pattern matches in the word; reset 0.
- res_ready  in  1  collector accepts the result.
- busy  out  1  high in any state except IDLE; reset 0.

## Operation
- FSM states: IDLE, SHIFT, DRAIN, REPORT. Reset state is IDLE, with last_grant=1 so channel 0 wins first.
- IDLE behaviour:
  - If any req_valid is set, grant the channel that is not last_grant when both are valid; otherwise grant the single valid channel.
  - Assert req_ready[g] for that cycle and load the shift register with req_data{g}.
  - Set res_id=g, last_grant=g, hits=0, bitcnt=0, and pulse the core's synchronous clr.
  - Go to SHIFT.
- SHIFT behaviour:
  - Core input seq is shreg[WIDTH-1]; shreg shifts left by one each cycle and bitcnt increments.
  - When the core's b=1, hits increments and saturates at 2^CNT_W-1.
  - After WIDTH bits have been driven, go to DRAIN.
- DRAIN: one cycle that counts b for the final bit. The core input is driven 0, which has no effect because the core is cleared before the next use. Then go to REPORT.
- REPORT: res_valid=1, with res_id and res_hits held stable until res_ready=1. On that cycle, go to IDLE. No new request is accepted in REPORT.
- Core transitions (state ← next on seq, with b registered):
  - Idle: 0→Idle, 1→S1.
  - S1: 0→S10, 1→S1.
  - S10: 0→Idle, 1→S101.
  - S101: 0→Idle, 1→S1011.
  - S1011: 0→S10110, 1→S1.
  - S10110: 0→Idle with b=1; 1→S1.
  - b=0 on every other transition. clr forces state Idle and b=0 synchronously.
  - After a hit the core restarts from Idle; no overlap with the tail of the match.
- Matches never span words, because the core is cleared on each accept.
- Reset mid-operation: every output returns to its reset value immediately. An in-flight word is discarded with no result.

## Timing
- Accept at cycle 0. Bits are driven in cycles 1..WIDTH; DRAIN is cycle WIDTH+1; res_valid first rises in cycle WIDTH+2.
- b for the bit driven in cycle k is observed in cycle k+1.
- Minimum spacing between two accepts is WIDTH+3 cycles when res_ready is held at 1.
- req_ready is never asserted while busy=1. Both bits of req_ready are never high together.

## Structure
- Shared package holds the FSM state encoding for the scheduler and core, and the default values of WIDTH and CNT_W.
- One sub-module, seq_det_core: the 6-state detector with clk, rst, clr, seq, b. It is instantiated once; the scheduler is its only driver.

## Test plan
- **Two hits:** ch0 word 16'b1011_0010_1100_0000 with res_ready=1. Expect req_ready=2'b01 at cycle 0, res_valid at cycle 18, res_id=0, res_hits=2.
- **No hits:** ch1 word 16'hFFFF, then 16'h0000. Both produce res_hits=0 and res_id=1.
- **Arbitration:** both channels valid continuously. Grants alternate 0,1,0,1; a result is issued for each grant, in grant order.
- **Cross-word isolation:** ch0 sends 16'h000B, then 16'h0000. Both report 0 hits; no match spans the two words.
- **Back-pressure:** res_ready=0 for 10 cycles in REPORT. res_valid, res_id and res_hits stay stable, and req_ready stays 0. Release res_ready; the next accept occurs on the cycle after the handshake.
- **Reset mid-SHIFT:** rst low at cycle 5. All outputs go to reset values at once and no result is produced. After release, the first request is granted to ch0.
